// File: rtl/serial_word_receiver_if.sv
// ============================================================================
// serial_word_receiver_if : serial bit link plus parallel valid/ready word port
// Revision 1.0
// ============================================================================
`default_nettype none

interface serial_word_receiver_if #(
  parameter int WIDTH = 8
);
  logic             s_din;
  logic             s_bit_en;
  logic             s_sof;
  logic [WIDTH-1:0] p_dout;
  logic             p_valid;
  logic             p_ready;

  // master: serial source and parallel consumer; slave: the receiver itself
  modport master (
    output s_din, s_bit_en, s_sof, p_ready,
    input  p_dout, p_valid
  );

  modport slave (
    input  s_din, s_bit_en, s_sof, p_ready,
    output p_dout, p_valid
  );
endinterface

`default_nettype wire

// File: rtl/serial_word_receiver.sv
// ============================================================================
// serial_word_receiver : assembles framed serial bits into WIDTH-bit words
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_word_receiver #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic                         clk,
  input  wire logic                         rst_n,
  input  wire logic                         clr,
  serial_word_receiver_if.slave             link,
  output logic                              busy,
  output logic [$clog2(WIDTH+1)-1:0]        bit_cnt,
  output logic                              overrun,
  output logic                              frame_err
);

  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sr;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_first;
  logic               w_accept;
  logic               w_last_bit;

  // First bit is shifted into an all-zero register so both orders land correctly
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {sr[WIDTH-2:0], link.s_din};
      assign w_first   = {{(WIDTH-1){1'b0}}, link.s_din};
    end else begin : g_lsb_first
      assign w_shifted = {link.s_din, sr[WIDTH-1:1]};
      assign w_first   = {link.s_din, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  assign w_accept   = link.p_valid & link.p_ready;
  assign w_last_bit = (bit_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sr           <= '0;
      bit_cnt      <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
      link.p_dout  <= '0;
      link.p_valid <= 1'b0;
    end else if (clr) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
      link.p_valid <= 1'b0;
    end else begin
      if (w_accept)
        link.p_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (link.s_bit_en && link.s_sof) begin
            sr      <= w_first;
            bit_cnt <= CNT_W'(1);
            busy    <= 1'b1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (link.s_bit_en) begin
            if (link.s_sof) begin
              frame_err <= 1'b1;
              sr        <= w_first;
              bit_cnt   <= CNT_W'(1);
            end else if (w_last_bit) begin
              sr      <= w_shifted;
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
              // A completed word only replaces the holding register if it is free this cycle
              if (!link.p_valid || w_accept) begin
                link.p_dout  <= w_shifted;
                link.p_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              sr      <= w_shifted;
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
